// File: rtl/ahb_dma_master.sv
// -----------------------------------------------------------------------------
// ahb_dma_master
// Single-channel, word-wise memory-to-memory DMA engine acting as an AHB-lite
// initiator. Each word is moved with one non-pipelined read (address phase,
// then data phase) followed by one write (address phase, then data phase).
// Every bus-facing output and every status output comes straight from a flop.
//
// Optional build macro:
//   AHB_DMA_SRC_FIXED_EN - adds the src_fixed input. When src_fixed is latched
//                          as 1 at start, the source address is not advanced,
//                          so a peripheral FIFO can be drained.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HADDR/HTRANS/HWRITE  master address-phase signals (IDLE or NONSEQ only)
//   HSIZE                constant word size (3'b010)
//   HWDATA               write data, held for the whole write data phase
//   HREADY/HRDATA/HRESP  slave response from the bus mux
//   start                one-cycle pulse; latches src/dst/count when idle
//   abort                level; honoured when a word's write completes
//   src_addr, dst_addr   word-aligned byte addresses (low bits ignored)
//   count                number of words to move
//   src_fixed            (optional) keep the source address constant
//   busy                 transfer in progress
//   done                 one-cycle pulse at completion, abort or error
//   err                  sticky bus-error flag, cleared by an accepted start
//   irq                  level interrupt, set with done, cleared by start
// -----------------------------------------------------------------------------
module ahb_dma_master #(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA,
  input  logic             HRESP,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
`ifdef AHB_DMA_SRC_FIXED_EN
  input  logic             src_fixed,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             irq
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RA,
    ST_RD,
    ST_WA,
    ST_WD
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [31:0]      haddr_q, haddr_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             hwrite_q, hwrite_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             irq_q, irq_d;
  logic             fixed_q, fixed_d;
  logic             finish;

  // Address bits [1:0] are deliberately discarded (word transfers only).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    hwdata_d = hwdata_q;
    err_d    = err_q;
    irq_d    = irq_q;
    fixed_d  = fixed_q;
    done_d   = 1'b0;
    finish   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d = {src_addr[31:2], 2'b00};
          dst_d = {dst_addr[31:2], 2'b00};
          rem_d = count;
          err_d = 1'b0;
          irq_d = 1'b0;
`ifdef AHB_DMA_SRC_FIXED_EN
          fixed_d = src_fixed;
`else
          fixed_d = 1'b0;
`endif
          if (count == '0) finish = 1'b1;
          else             state_d = ST_RA;
        end
      end
      ST_RA: begin
        if (HREADY) state_d = ST_RD;
      end
      ST_RD: begin
        // HRESP with HREADY low is the first cycle of an ERROR response:
        // wait for its second cycle before leaving the data phase.
        if (HREADY) begin
          if (HRESP) begin
            err_d  = 1'b1;
            finish = 1'b1;
          end else begin
            hwdata_d = HRDATA;
            state_d  = ST_WA;
          end
        end
      end
      ST_WA: begin
        if (HREADY) state_d = ST_WD;
      end
      ST_WD: begin
        if (HREADY) begin
          if (HRESP) begin
            err_d  = 1'b1;
            finish = 1'b1;
          end else begin
            src_d = fixed_q ? src_q : src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1) || abort) finish = 1'b1;
            else                              state_d = ST_RA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      irq_d   = 1'b1;
    end

    // Outputs are a function of the state being entered, so they are
    // registered yet line up with the state they describe.
    htrans_d = (state_d == ST_RA || state_d == ST_WA) ? TR_NONSEQ : TR_IDLE;
    hwrite_d = (state_d == ST_WA);
    haddr_d  = haddr_q;
    if (state_d == ST_RA)      haddr_d = src_d;
    else if (state_d == ST_WA) haddr_d = dst_d;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      htrans_q <= TR_IDLE;
      hwrite_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      fixed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
      fixed_q  <= fixed_d;
    end
  end

  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = 3'b010;
  assign HWDATA = hwdata_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_ahb_dma_master.sv
// -----------------------------------------------------------------------------
// tb_ahb_dma_master
// Bench for ahb_dma_master: an AHB-lite slave model with memory, wait states,
// address-phase stalls and two-cycle ERROR responses; a table of directed
// transfers plus randomized transfers, each checked against a transfer-level
// model (expected read/write address lists, copied data, word count, flags and
// cycle count); hand-written reset sequences.
// Build with +define+AHB_DMA_SRC_FIXED_EN to include the fixed-source case.
// -----------------------------------------------------------------------------
module tb_ahb_dma_master;
  localparam int         CNT_W  = 16;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic             HCLK    = 1'b0;
  logic             HRESETn = 1'b0;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [31:0]      HWDATA;
  logic             HREADY  = 1'b1;
  logic [31:0]      HRDATA  = '0;
  logic             HRESP   = 1'b0;
  logic             start   = 1'b0;
  logic             abort   = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [CNT_W-1:0] count    = '0;
`ifdef AHB_DMA_SRC_FIXED_EN
  logic             src_fixed = 1'b0;
`endif
  logic             busy, done, err, irq;

  ahb_dma_master #(.CNT_W(CNT_W)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HRDATA   (HRDATA),
    .HRESP    (HRESP),
    .start    (start),
    .abort    (abort),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
`ifdef AHB_DMA_SRC_FIXED_EN
    .src_fixed(src_fixed),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err),
    .irq      (irq)
  );

  always #5 HCLK = ~HCLK;

  // One directed or random transfer: stimulus plus expected outcome.
  // wmode 0..2 = fixed wait states per data phase, 3 = random 0..2.
  // exp_cyc < 0 means: derive the cycle count from phases + inserted waits.
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          cnt;
    int          wmode;
    bit          stall;
    int          err_word;
    bit          err_wr;
    int          abort_word;
    bit          fixed;
    bit          restart;
    int          exp_words;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- slave model
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q[$];
  logic [63:0] wr_q[$];
  int          rd_idx = 0, wr_idx = 0, low_cnt = 0;
  int          cfg_wmode = 0, cfg_err_word = 0;
  bit          cfg_stall = 0, cfg_err_wr = 0;
  bit          dp_active = 0, dp_write = 0, dp_err = 0, err_stage = 0;
  logic [31:0] dp_addr = '0;
  int          dp_wait = 0;
  logic        prev_hready = 1'b1, prev_hwrite = 1'b0;
  logic [1:0]  prev_htrans = 2'b00;
  logic [31:0] prev_haddr = '0, prev_hwdata = '0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  // Everything happens on the falling edge: the previous cycle is retired
  // using what was on the bus at the rising edge, then this cycle's response
  // is driven.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_active   = 0;
      HREADY      = 1'b1;
      HRESP       = 1'b0;
      prev_hready = 1'b1;
      prev_htrans = 2'b00;
    end else begin
      // bus protocol monitor
      if (prev_htrans == NONSEQ && !prev_hready) begin
        chk("addr_hold_htrans", 32'(HTRANS), 32'(prev_htrans));
        chk("addr_hold_haddr", HADDR, prev_haddr);
        chk("addr_hold_hwrite", 32'(HWRITE), 32'(prev_hwrite));
      end
      if (dp_active && dp_write && !prev_hready)
        chk("hwdata_hold", HWDATA, prev_hwdata);
      chk("busy_done_excl", 32'(busy & done), 0);
      chk("hsize_word", 32'(HSIZE), 32'd2);
      chk("htrans_legal", 32'(HTRANS == 2'b01 || HTRANS == 2'b11), 0);
      if (HTRANS == NONSEQ) chk("haddr_aligned", 32'(HADDR[1:0]), 0);

      // retire the cycle that just ended
      if (prev_hready) begin
        if (dp_active) begin
          if (dp_write && !dp_err) begin
            wr_q.push_back({dp_addr, prev_hwdata});
            mem[dp_addr] = prev_hwdata;
          end
          dp_active = 0;
        end
        if (prev_htrans == NONSEQ) begin
          dp_active = 1;
          dp_addr   = prev_haddr;
          dp_write  = prev_hwrite;
          err_stage = 0;
          if (!prev_hwrite) begin
            rd_idx++;
            rd_q.push_back(prev_haddr);
            dp_err = (cfg_err_word == rd_idx) && !cfg_err_wr;
          end else begin
            wr_idx++;
            dp_err = (cfg_err_word == wr_idx) && cfg_err_wr;
          end
          dp_wait = (cfg_wmode == 3) ? int'($urandom_range(0, 2)) : cfg_wmode;
        end
      end

      // drive this cycle's response
      HRESP  = 1'b0;
      HRDATA = $urandom;
      if (dp_active) begin
        if (dp_err) begin
          HRESP     = 1'b1;
          HREADY    = err_stage;
          err_stage = 1;
        end else if (dp_wait > 0) begin
          HREADY = 1'b0;
          dp_wait--;
        end else begin
          HREADY = 1'b1;
          if (!dp_write) HRDATA = mem_rd(dp_addr);
        end
      end else begin
        HREADY = !(cfg_stall && ($urandom_range(0, 2) == 0));
      end
      if (!HREADY && busy) low_cnt++;

      prev_hready = HREADY;
      prev_htrans = HTRANS;
      prev_haddr  = HADDR;
      prev_hwrite = HWRITE;
      prev_hwdata = HWDATA;
    end
  end

  // ------------------------------------------------------------ transfer runner
  task automatic run_vec(input int id, input vec_t v);
    int          n, done_cnt, ra_cnt, extra_ns, exp_reads, exp_cyc;
    bit          prev_ra, ra_now, got_done;
    logic [31:0] base, raddr;

    @(negedge HCLK);
    mem.delete();
    rd_q.delete();
    wr_q.delete();
    rd_idx       = 0;
    wr_idx       = 0;
    low_cnt      = 0;
    cfg_wmode    = v.wmode;
    cfg_stall    = v.stall;
    cfg_err_word = v.err_word;
    cfg_err_wr   = v.err_wr;
    src_addr     = v.src;
    dst_addr     = v.dst;
    count        = CNT_W'(v.cnt);
`ifdef AHB_DMA_SRC_FIXED_EN
    src_fixed    = v.fixed;
`endif
    start        = 1'b1;

    base     = {v.src[31:2], 2'b00};
    n        = 0;
    got_done = 0;
    ra_cnt   = 0;
    prev_ra  = 0;
    while (n < 400 && !got_done) begin
      @(negedge HCLK);
      start = 1'b0;
      n++;
      if (n == 1) begin
        if (v.cnt != 0) begin
          chk("first_busy", 32'(busy), 1);
          chk("first_htrans", 32'(HTRANS), 32'(NONSEQ));
          chk("first_hwrite", 32'(HWRITE), 0);
          chk("first_haddr", HADDR, base);
          chk("start_clears_err", 32'(err), 0);
          chk("start_clears_irq", 32'(irq), 0);
        end else begin
          chk("cnt0_busy", 32'(busy), 0);
          chk("cnt0_htrans", 32'(HTRANS), 0);
          chk("cnt0_irq", 32'(irq), 1);
        end
      end
      // A second start mid-transfer with different settings must be ignored.
      if (v.restart && n == 5) begin
        start    = 1'b1;
        src_addr = v.src + 32'h40;
        count    = CNT_W'(1);
      end
      ra_now = (HTRANS == NONSEQ) && !HWRITE;
      if (ra_now && !prev_ra) ra_cnt++;
      prev_ra = ra_now;
      if (v.abort_word != 0 && ra_cnt >= v.abort_word) abort = 1'b1;
      if (done) got_done = 1;
    end
    start = 1'b0;
    abort = 1'b0;
    chk("done_seen", 32'(got_done), 1);

    done_cnt = got_done ? 1 : 0;
    extra_ns = 0;
    repeat (3) begin
      @(negedge HCLK);
      if (done) done_cnt++;
      if (HTRANS == NONSEQ) extra_ns++;
    end

    exp_reads = v.exp_words + (v.exp_err ? 1 : 0);
    if (v.exp_cyc >= 0) exp_cyc = v.exp_cyc;
    else exp_cyc = 4 * v.exp_words + (v.exp_err ? (v.err_wr ? 4 : 2) : 0) + low_cnt;

    chk("done_pulses", done_cnt, 1);
    chk("extra_nonseq", extra_ns, 0);
    chk("err_flag", 32'(err), 32'(v.exp_err));
    chk("irq_flag", 32'(irq), 1);
    chk("busy_end", 32'(busy), 0);
    chk("read_count", rd_q.size(), exp_reads);
    chk("write_count", wr_q.size(), v.exp_words);
    for (int j = 0; j < rd_q.size() && j < exp_reads; j++) begin
      raddr = v.fixed ? base : base + 32'(4 * j);
      chk("read_addr", rd_q[j], raddr);
    end
    for (int j = 0; j < wr_q.size() && j < v.exp_words; j++) begin
      raddr = v.fixed ? base : base + 32'(4 * j);
      chk("write_addr", wr_q[j][63:32], {v.dst[31:2], 2'b00} + 32'(4 * j));
      chk("write_data", wr_q[j][31:0], pat(raddr));
    end
    if (v.cnt == 0) chk("cnt0_latency", n, 1);
    else            chk("cycles", n - 1, exp_cyc);

    $display("vec %0d: src=%h dst=%h cnt=%0d words=%0d/%0d err=%0b cycles=%0d",
             id, v.src, v.dst, v.cnt, wr_q.size(), v.exp_words, err, n - 1);
  endtask

  // ------------------------------------------------------------------ main test
  initial begin
    vec_t tbl[$];
    vec_t v;
    int   k;

    // src, dst, cnt, wmode, stall, err_word, err_wr, abort_word, fixed, restart,
    // exp_words, exp_err, exp_cyc
    tbl.push_back('{32'h2000_0000, 32'h2000_0100, 3, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 3, 1'b0, 12});
    // two extra cycles in each of the six data phases
    tbl.push_back('{32'h2000_0000, 32'h2000_0100, 3, 2, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 24});
    tbl.push_back('{32'h2000_0000, 32'h2000_0100, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0});
    tbl.push_back('{32'h2100_0000, 32'h2100_0100, 5, 0, 1'b0, 0, 1'b0, 2, 1'b0, 1'b0, 2, 1'b0, 8});
    // word 1 (4) + read address (1) + two-cycle ERROR (2)
    tbl.push_back('{32'h2200_0000, 32'h2200_0100, 4, 0, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 1, 1'b1, 7});
    tbl.push_back('{32'h2300_0000, 32'h2300_0100, 1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1, 1'b0, 4});
    tbl.push_back('{32'hFFFF_FFFC, 32'h1000_0000, 2, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 2, 1'b0, 8});
    tbl.push_back('{32'h5000_0000, 32'h5000_0800, 3, 1, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 2, 1'b1, -1});
`ifdef AHB_DMA_SRC_FIXED_EN
    tbl.push_back('{32'h4000_0000, 32'h4000_0100, 3, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 3, 1'b0, 12});
`endif

    // reset values
    #2;
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", 32'(HWRITE), 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_hsize", 32'(HSIZE), 32'd2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_irq", 32'(irq), 0);
    @(negedge HCLK);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // reset while the write address phase is on the bus
    @(negedge HCLK);
    mem.delete();
    cfg_wmode    = 0;
    cfg_stall    = 0;
    cfg_err_word = 0;
    src_addr     = 32'h3000_0000;
    dst_addr     = 32'h3000_1000;
    count        = CNT_W'(3);
    start        = 1'b1;
    k = 0;
    while (k < 50 && !(HTRANS == NONSEQ && HWRITE)) begin
      @(negedge HCLK);
      start = 1'b0;
      k++;
    end
    start = 1'b0;
    chk("reached_wa", 32'(HTRANS == NONSEQ && HWRITE), 1);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_rst_htrans", 32'(HTRANS), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_haddr", HADDR, 0);
    chk("async_rst_hwrite", 32'(HWRITE), 0);
    chk("async_rst_hwdata", HWDATA, 0);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      chk("idle_after_rst", 32'(HTRANS), 0);
    end
    $display("reset-in-WA sequence done");

    // randomized transfers
    for (int r = 0; r < 25; r++) begin
      v.src        = $urandom & 32'hFFFF_FFFC;
      v.dst        = v.src ^ 32'h8000_0000;
      v.cnt        = $urandom_range(0, 6);
      v.wmode      = 3;
      v.stall      = 1'b1;
      v.err_word   = 0;
      v.err_wr     = 1'b0;
      v.abort_word = 0;
      v.restart    = 1'b0;
      v.exp_cyc    = -1;
`ifdef AHB_DMA_SRC_FIXED_EN
      v.fixed      = 1'($urandom_range(0, 1));
`else
      v.fixed      = 1'b0;
`endif
      if (v.cnt > 0 && $urandom_range(0, 3) == 0) begin
        v.err_word = $urandom_range(1, v.cnt);
        v.err_wr   = 1'($urandom_range(0, 1));
      end else if (v.cnt > 1 && $urandom_range(0, 3) == 0) begin
        v.abort_word = $urandom_range(1, v.cnt);
      end
      if (v.err_word != 0) begin
        v.exp_words = v.err_word - 1;
        v.exp_err   = 1'b1;
      end else begin
        v.exp_words = (v.abort_word != 0) ? v.abort_word : v.cnt;
        v.exp_err   = 1'b0;
      end
      run_vec(100 + r, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish: actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
